// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order imem requests, buffers returned words
// with their PCs, and flushes/redirects on taken branches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [CW-1:0] drop;
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] buf_wr;
  logic [PW-1:0] buf_rd;

  logic [31:0] tag_pc    [DEPTH];
  logic [31:0] buf_instr [DEPTH];
  logic [31:0] buf_pc    [DEPTH];

  logic        req_hs;
  logic        pop;
  logic        rsp_accept;
  logic        rsp_keep;
  logic [CW:0] occupancy;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts in-flight requests (including ones to be dropped) plus
  // buffered words, so every issued request is guaranteed a buffer slot.
  assign instr_valid_o = !reset && !redirect_i && (count != '0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign occupancy     = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem_req_o    = !reset && !redirect_i && (occupancy < DEPTH_W);
  assign req_hs        = imem_req_o && imem_ready_i;
  assign rsp_accept    = !reset && imem_rvalid_i && (outstanding != '0);
  assign rsp_keep      = rsp_accept && !redirect_i && (drop == '0);

  assign imem_addr_o = fetch_pc;
  assign instr_o     = buf_instr[buf_rd];
  assign instr_pc_o  = buf_pc[buf_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      drop        <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_hs) - CW'(rsp_accept);
      if (req_hs) tag_wr <= next_ptr(tag_wr);
      if (rsp_accept) tag_rd <= next_ptr(tag_rd);

      // Requests still in flight after a redirect belong to the old path.
      if (redirect_i) begin
        fetch_pc <= redirect_pc_i & ~32'h3;
        count    <= '0;
        buf_wr   <= '0;
        buf_rd   <= '0;
        drop     <= outstanding - CW'(rsp_accept);
      end else begin
        if (req_hs) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_accept && (drop != '0)) drop <= drop - CW'(1);
        if (rsp_keep) buf_wr <= next_ptr(buf_wr);
        if (pop) buf_rd <= next_ptr(buf_rd);
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) tag_pc[tag_wr] <= fetch_pc;
    if (rsp_keep) begin
      buf_instr[buf_wr] <= imem_rdata_i;
      buf_pc[buf_wr]    <= tag_pc[tag_rd];
    end
  end

endmodule
